param_cpu: RTL and testbench
============================

# param_cpu

Parametrised multi-cycle accumulator-style CPU with an internal loadable program memory, a register file of NREGS × DATA_W registers, a 16-operation instruction set with Z/C flags, conditional jumps, an output port and a halt state. It is the core-level block: host logic loads a program through the write port, pulses `start`, and observes `out_data`/`out_valid` plus a debug register read port.

## Interface
- DATA_W, 8, datapath and register width (≥4)
- NREGS, 4, register count (power of 2, ≥2); RW = clog2(NREGS)
- PC_W, 4, program counter width; program memory depth 2^PC_W
- Derived IW = 4 + 2·RW + DATA_W, instruction width ({op[3:0], rd, rs, imm}, op in MSBs)

- clk  in  1  clock; all state changes on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  begin execution at address 0; honoured only in IDLE or HALT
- prog_we  in  1  program memory write strobe; honoured only in IDLE or HALT
- prog_addr  in  PC_W  program memory write address
- prog_data  in  IW  program memory write data
- dbg_sel  in  RW  debug register select
- dbg_data  out  DATA_W  combinational: regs[dbg_sel]
- pc  out  PC_W  current program counter
- busy  out  1  high in FETCH/DECODE/EXEC
- halted  out  1  high in HALT
- flag_z, flag_c  out  1  zero / carry flags
- out_data  out  DATA_W  last OUT value (held)
- out_valid  out  1  one-cycle pulse per OUT

## Operation
- FSM: IDLE → (start) FETCH → DECODE → EXEC → FETCH …; EXEC of HALT → HALT; HALT → (start) FETCH.
- FETCH: synchronous memory read at pc. DECODE: instruction latched. EXEC: execute, update pc.
- start: pc←0, flags←0; registers and out_data retained.
- Opcodes (rd/rs index registers, imm = low DATA_W bits):
  - 0 NOP; 1 LDI rd←imm; 2 MOV rd←rs
  - 3 ADD rd←rd+rs, C = carry out; 4 SUB rd←rd−rs, C = borrow (rd<rs unsigned)
  - 5 AND, 6 OR, 7 XOR (rd←rd op rs, C←0)
  - 8 SHL rd←rd<<1, C←old msb; 9 SHR rd←rd>>1 logical, C←old lsb
  - A JMP pc←imm[PC_W-1:0]; B JZ if Z; C JC if C (else pc+1)
  - D OUT out_data←rs, out_valid pulse; E HALT; F reserved = NOP
- Z updated by ops 3–9 only (Z = result==0); C only by ops 3–9. Other ops leave flags unchanged.
- Arithmetic modulo 2^DATA_W. pc+1 modulo 2^PC_W (wraps to 0; no fault).
- rd==rs legal (ADD r,r doubles; SUB r,r → 0, Z=1, C=0).
- Program memory not cleared by reset; contents undefined until written.

## Timing
- Reset values: pc 0, all registers 0, flag_z/flag_c 0, out_data 0, out_valid 0, busy 0, halted 0, state IDLE.
- Reset mid-instruction: aborts, all above values restored next edge; no partial register write.
- 3 cycles per instruction, taken or not; first FETCH in cycle after start accepted.
- Register/flag results visible the cycle after EXEC; next instruction's DECODE sees them.
- out_valid high exactly the cycle after OUT's EXEC edge; out_data valid same cycle and held.
- start or prog_we while busy: ignored, no side effect. start and prog_we same cycle in IDLE/HALT: write performed, execution starts; the FETCH issued next cycle sees the new word.
- HALT: busy falls and halted rises the cycle after HALT's EXEC; pc points to HALT's address +1.
- dbg_data purely combinational; reflects write on the cycle after EXEC.

## Test plan
- Reset values: assert reset 2 cycles mid-run → all outputs at reset values, IDLE, busy 0.
- LDI r0,5; LDI r1,3; ADD r0,r1; OUT r0; HALT, start → out_data 8 with one-cycle out_valid, Z=0 C=0, halted after 15 cycles.
- Carry/zero: LDI r0,0xFF; LDI r1,1; ADD r0,r1 → r0=0x00, Z=1, C=1; SUB r1,r0 → r1=1, C=0; SUB r0,r1 → 0xFF, C=1.
- Loop: r0←3, r1←1; loop SUB r0,r1; JZ end; JMP loop; end OUT r0; HALT → out_data 0, exactly one out_valid.
- PC wrap: no HALT, NOPs at 14–15, LDI r2,7 at 0 → pc goes 15→0, r2 rewritten 7; mid-run prog_we ignored (memory readback unchanged).
- Restart: after HALT, rewrite address 0, start → new program runs from 0, flags cleared, registers retained.

Source files
------------

// File: rtl/param_cpu.sv
// param_cpu: multi-cycle accumulator-style CPU core.
// A host loads the program memory while the core is idle or halted, pulses
// start, and then watches out_data/out_valid and the debug register port.
// Each instruction takes exactly three cycles: FETCH, DECODE, EXEC.
module param_cpu #(
   parameter int  DATA_W = 8,
   parameter int  NREGS  = 4,
   parameter int  PC_W   = 4,
   localparam int RW     = $clog2(NREGS),
   localparam int IW     = 4 + 2 * RW + DATA_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              prog_we,
   input  logic [PC_W-1:0]   prog_addr,
   input  logic [IW-1:0]     prog_data,
   input  logic [RW-1:0]     dbg_sel,
   output logic [DATA_W-1:0] dbg_data,
   output logic [PC_W-1:0]   pc,
   output logic              busy,
   output logic              halted,
   output logic              flag_z,
   output logic              flag_c,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_HALT   = 3'd4
   } state_t;

   state_t            state_q;
   logic [IW-1:0]     mem_q [2**PC_W];
   logic [IW-1:0]     ir_q;
   logic [DATA_W-1:0] regs_q [NREGS];
   logic [PC_W-1:0]   pc_q;
   logic              flag_z_q;
   logic              flag_c_q;
   logic [DATA_W-1:0] out_data_q;
   logic              out_valid_q;
   logic              busy_q;
   logic              halted_q;

   // Instruction fields of the latched word: {op, rd, rs, imm}
   logic [3:0]        op;
   logic [RW-1:0]     rd_idx;
   logic [RW-1:0]     rs_idx;
   logic [DATA_W-1:0] imm;
   logic [DATA_W-1:0] rd_val;
   logic [DATA_W-1:0] rs_val;
   logic              loadable;

   logic [DATA_W-1:0] alu_res_d;
   logic              alu_c_d;
   logic              reg_wr_d;
   logic              flag_wr_d;
   logic [PC_W-1:0]   pc_next_d;
   logic [PC_W-1:0]   pc_inc;

   assign op       = ir_q[IW-1 -: 4];
   assign rd_idx   = ir_q[IW-5 -: RW];
   assign rs_idx   = ir_q[IW-5-RW -: RW];
   assign imm      = ir_q[DATA_W-1:0];
   assign rd_val   = regs_q[rd_idx];
   assign rs_val   = regs_q[rs_idx];
   assign pc_inc   = pc_q + PC_W'(1);
   // Program loads and start are only honoured when nothing is executing
   assign loadable = (state_q == S_IDLE) || (state_q == S_HALT);

   assign dbg_data  = regs_q[dbg_sel];
   assign pc        = pc_q;
   assign busy      = busy_q;
   assign halted    = halted_q;
   assign flag_z    = flag_z_q;
   assign flag_c    = flag_c_q;
   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;

   // Program memory write port; contents are deliberately not reset
   always_ff @(posedge clk) begin
      if (prog_we && loadable && !reset) begin
         mem_q[prog_addr] <= prog_data;
      end
   end

   // ALU, flag generation and next-pc selection for the instruction in EXEC
   always_comb begin
      alu_res_d = rd_val;
      alu_c_d   = 1'b0;
      reg_wr_d  = 1'b0;
      flag_wr_d = 1'b0;
      pc_next_d = pc_inc;
      case (op)
         4'h1: begin
            alu_res_d = imm;
            reg_wr_d  = 1'b1;
         end
         4'h2: begin
            alu_res_d = rs_val;
            reg_wr_d  = 1'b1;
         end
         4'h3: begin
            {alu_c_d, alu_res_d} = {1'b0, rd_val} + {1'b0, rs_val};
            reg_wr_d  = 1'b1;
            flag_wr_d = 1'b1;
         end
         4'h4: begin
            // The extra top bit of the difference is the unsigned borrow
            {alu_c_d, alu_res_d} = {1'b0, rd_val} - {1'b0, rs_val};
            reg_wr_d  = 1'b1;
            flag_wr_d = 1'b1;
         end
         4'h5: begin
            alu_res_d = rd_val & rs_val;
            reg_wr_d  = 1'b1;
            flag_wr_d = 1'b1;
         end
         4'h6: begin
            alu_res_d = rd_val | rs_val;
            reg_wr_d  = 1'b1;
            flag_wr_d = 1'b1;
         end
         4'h7: begin
            alu_res_d = rd_val ^ rs_val;
            reg_wr_d  = 1'b1;
            flag_wr_d = 1'b1;
         end
         4'h8: begin
            alu_res_d = {rd_val[DATA_W-2:0], 1'b0};
            alu_c_d   = rd_val[DATA_W-1];
            reg_wr_d  = 1'b1;
            flag_wr_d = 1'b1;
         end
         4'h9: begin
            alu_res_d = {1'b0, rd_val[DATA_W-1:1]};
            alu_c_d   = rd_val[0];
            reg_wr_d  = 1'b1;
            flag_wr_d = 1'b1;
         end
         4'hA: begin
            pc_next_d = imm[PC_W-1:0];
         end
         4'hB: begin
            if (flag_z_q) begin
               pc_next_d = imm[PC_W-1:0];
            end else begin
               pc_next_d = pc_inc;
            end
         end
         4'hC: begin
            if (flag_c_q) begin
               pc_next_d = imm[PC_W-1:0];
            end else begin
               pc_next_d = pc_inc;
            end
         end
         default: begin
            // NOP, OUT, HALT and the reserved opcode only advance pc
            pc_next_d = pc_inc;
         end
      endcase
   end

   // Control FSM, register file, flags and output port state
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         ir_q        <= {IW{1'b0}};
         pc_q        <= {PC_W{1'b0}};
         flag_z_q    <= 1'b0;
         flag_c_q    <= 1'b0;
         out_data_q  <= {DATA_W{1'b0}};
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         halted_q    <= 1'b0;
         for (int i = 0; i < NREGS; i++) begin
            regs_q[i] <= {DATA_W{1'b0}};
         end
      end else begin
         out_valid_q <= 1'b0;
         case (state_q)
            S_IDLE, S_HALT: begin
               if (start) begin
                  state_q  <= S_FETCH;
                  pc_q     <= {PC_W{1'b0}};
                  flag_z_q <= 1'b0;
                  flag_c_q <= 1'b0;
                  busy_q   <= 1'b1;
                  halted_q <= 1'b0;
               end
            end
            S_FETCH: begin
               ir_q    <= mem_q[pc_q];
               state_q <= S_DECODE;
            end
            S_DECODE: begin
               state_q <= S_EXEC;
            end
            S_EXEC: begin
               pc_q <= pc_next_d;
               if (reg_wr_d) begin
                  regs_q[rd_idx] <= alu_res_d;
               end
               if (flag_wr_d) begin
                  flag_z_q <= (alu_res_d == {DATA_W{1'b0}});
                  flag_c_q <= alu_c_d;
               end
               if (op == 4'hD) begin
                  out_data_q  <= rs_val;
                  out_valid_q <= 1'b1;
               end
               if (op == 4'hE) begin
                  state_q  <= S_HALT;
                  busy_q   <= 1'b0;
                  halted_q <= 1'b1;
               end else begin
                  state_q <= S_FETCH;
               end
            end
            default: begin
               state_q  <= S_IDLE;
               busy_q   <= 1'b0;
               halted_q <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_param_cpu.sv
// Scoreboard bench for param_cpu: directed programs with hand-computed
// results; OUT values are queued at stimulus time and popped by a monitor.
module tb_param_cpu;

   logic        clk;
   logic        reset;
   logic        start;
   logic        prog_we;
   logic [3:0]  prog_addr;
   logic [15:0] prog_data;
   logic [1:0]  dbg_sel;
   logic [7:0]  dbg_data;
   logic [3:0]  pc;
   logic        busy;
   logic        halted;
   logic        flag_z;
   logic        flag_c;
   logic [7:0]  out_data;
   logic        out_valid;

   int          checks;
   int          failures;
   logic [7:0]  exp_q[$];
   logic [15:0] prog_q[$];

   param_cpu dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .prog_we   (prog_we),
      .prog_addr (prog_addr),
      .prog_data (prog_data),
      .dbg_sel   (dbg_sel),
      .dbg_data  (dbg_data),
      .pc        (pc),
      .busy      (busy),
      .halted    (halted),
      .flag_z    (flag_z),
      .flag_c    (flag_c),
      .out_data  (out_data),
      .out_valid (out_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [15:0] enc(input logic [3:0] op, input logic [1:0] rd,
                                       input logic [1:0] rs, input logic [7:0] imm);
      return {op, rd, rs, imm};
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%0h expected=%0h", nm, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk_reg(input string nm, input logic [1:0] idx, input logic [7:0] exp);
      dbg_sel = idx;
      #1;
      check(nm, {24'd0, dbg_data}, {24'd0, exp});
   endtask

   task automatic load(input logic [3:0] a, input logic [15:0] d);
      prog_we   = 1'b1;
      prog_addr = a;
      prog_data = d;
      tick(1);
      prog_we   = 1'b0;
   endtask

   task automatic load_q();
      for (int i = 0; i < prog_q.size(); i++) begin
         load(4'(i), prog_q[i]);
      end
      prog_q.delete();
   endtask

   task automatic wait_halt(input string nm, input int exp_cycles);
      int cyc;
      check({nm, "_busy"}, {31'd0, busy}, 32'd1);
      check({nm, "_flags_clr"}, {30'd0, flag_z, flag_c}, 32'd0);
      cyc = 0;
      while (!halted && cyc < 400) begin
         tick(1);
         cyc++;
      end
      check({nm, "_cycles"}, cyc, exp_cycles);
      check({nm, "_idle"}, {31'd0, busy}, 32'd0);
   endtask

   task automatic run_prog(input string nm, input int exp_cycles);
      start = 1'b1;
      tick(1);
      start = 1'b0;
      wait_halt(nm, exp_cycles);
   endtask

   // Monitor: every out_valid cycle must match the oldest queued expectation
   always @(negedge clk) begin
      if (!reset && out_valid) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL out_unexpected got=%0h expected=none", out_data);
         end else begin
            check("out_data", {24'd0, out_data}, {24'd0, exp_q.pop_front()});
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog got=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      checks    = 0;
      failures  = 0;
      reset     = 1'b1;
      start     = 1'b0;
      prog_we   = 1'b0;
      prog_addr = 4'd0;
      prog_data = 16'd0;
      dbg_sel   = 2'd0;
      tick(2);
      reset = 1'b0;
      check("rst_pc", {28'd0, pc}, 32'd0);
      check("rst_busy_halt", {30'd0, busy, halted}, 32'd0);
      check("rst_out", {23'd0, out_valid, out_data}, 32'd0);
      chk_reg("rst_r0", 2'd0, 8'd0);

      // Basic add and output
      prog_q = '{enc(4'h1, 2'd0, 2'd0, 8'd5), enc(4'h1, 2'd1, 2'd0, 8'd3),
                 enc(4'h3, 2'd0, 2'd1, 8'd0), enc(4'hD, 2'd0, 2'd0, 8'd0),
                 enc(4'hE, 2'd0, 2'd0, 8'd0)};
      load_q();
      exp_q.push_back(8'd8);
      run_prog("progA", 15);
      check("A_halted", {31'd0, halted}, 32'd1);
      check("A_pc", {28'd0, pc}, 32'd5);
      check("A_flags", {30'd0, flag_z, flag_c}, 32'd0);
      check("A_out_held", {24'd0, out_data}, 32'd8);
      chk_reg("A_r0", 2'd0, 8'd8);

      // Carry and zero from 0xFF + 1
      prog_q = '{enc(4'h1, 2'd0, 2'd0, 8'hFF), enc(4'h1, 2'd1, 2'd0, 8'd1),
                 enc(4'h3, 2'd0, 2'd1, 8'd0), enc(4'hE, 2'd0, 2'd0, 8'd0)};
      load_q();
      run_prog("progB", 12);
      chk_reg("B_r0", 2'd0, 8'h00);
      check("B_flags", {30'd0, flag_z, flag_c}, 32'd3);

      // Restart with registers retained: SUB r1,r0 -> 1, no borrow
      prog_q = '{enc(4'h4, 2'd1, 2'd0, 8'd0), enc(4'hE, 2'd0, 2'd0, 8'd0)};
      load_q();
      run_prog("progC", 6);
      chk_reg("C_r1", 2'd1, 8'd1);
      check("C_flags", {30'd0, flag_z, flag_c}, 32'd0);

      // SUB r0,r1 -> 0xFF with borrow; word 0 written in the same cycle as start
      load(4'd1, enc(4'hE, 2'd0, 2'd0, 8'd0));
      prog_we   = 1'b1;
      prog_addr = 4'd0;
      prog_data = enc(4'h4, 2'd0, 2'd1, 8'd0);
      start     = 1'b1;
      tick(1);
      prog_we   = 1'b0;
      start     = 1'b0;
      wait_halt("progD", 6);
      chk_reg("D_r0", 2'd0, 8'hFF);
      chk_reg("D_r1", 2'd1, 8'd1);
      check("D_flags", {30'd0, flag_z, flag_c}, 32'd1);

      // Countdown loop with a single OUT at the end
      prog_q = '{enc(4'h1, 2'd0, 2'd0, 8'd3), enc(4'h1, 2'd1, 2'd0, 8'd1),
                 enc(4'h4, 2'd0, 2'd1, 8'd0), enc(4'hB, 2'd0, 2'd0, 8'd5),
                 enc(4'hA, 2'd0, 2'd0, 8'd2), enc(4'hD, 2'd0, 2'd0, 8'd0),
                 enc(4'hE, 2'd0, 2'd0, 8'd0)};
      load_q();
      exp_q.push_back(8'd0);
      run_prog("loop", 36);
      check("loop_flags", {30'd0, flag_z, flag_c}, 32'd2);
      check("loop_pc", {28'd0, pc}, 32'd7);

      // Logic ops, shifts and a taken JC that skips an OUT; HALT at 15 wraps pc
      prog_q = '{enc(4'h1, 2'd2, 2'd0, 8'h96), enc(4'h1, 2'd3, 2'd0, 8'h3C),
                 enc(4'h2, 2'd1, 2'd2, 8'd0),  enc(4'h5, 2'd1, 2'd3, 8'd0),
                 enc(4'hD, 2'd0, 2'd1, 8'd0),  enc(4'h2, 2'd1, 2'd2, 8'd0),
                 enc(4'h6, 2'd1, 2'd3, 8'd0),  enc(4'hD, 2'd0, 2'd1, 8'd0),
                 enc(4'h7, 2'd2, 2'd3, 8'd0),  enc(4'hD, 2'd0, 2'd2, 8'd0),
                 enc(4'h8, 2'd2, 2'd0, 8'd0),  enc(4'hC, 2'd0, 2'd0, 8'd13),
                 enc(4'hD, 2'd0, 2'd3, 8'd0),  enc(4'h9, 2'd2, 2'd0, 8'd0),
                 enc(4'hD, 2'd0, 2'd2, 8'd0),  enc(4'hE, 2'd0, 2'd0, 8'd0)};
      load_q();
      exp_q.push_back(8'h14);
      exp_q.push_back(8'hBE);
      exp_q.push_back(8'hAA);
      exp_q.push_back(8'h2A);
      run_prog("logic", 45);
      check("logic_pc_wrap", {28'd0, pc}, 32'd0);
      check("logic_flags", {30'd0, flag_z, flag_c}, 32'd0);
      chk_reg("logic_r2", 2'd2, 8'h2A);

      // Free-running program: pc wraps 15 -> 0; writes and start while busy ignored
      prog_q = '{enc(4'h1, 2'd2, 2'd0, 8'd7), enc(4'h1, 2'd2, 2'd0, 8'd9)};
      for (int i = 2; i < 16; i++) prog_q.push_back(16'h0000);
      load_q();
      start = 1'b1;
      tick(1);
      start = 1'b0;
      tick(10);
      load(4'd1, enc(4'h1, 2'd2, 2'd0, 8'h55));
      start = 1'b1;
      tick(1);
      start = 1'b0;
      tick(38);
      check("wrap_pc0", {28'd0, pc}, 32'd0);
      chk_reg("wrap_r2_before", 2'd2, 8'd9);
      tick(1);
      chk_reg("wrap_r2_rewrite", 2'd2, 8'd7);
      check("wrap_pc1", {28'd0, pc}, 32'd1);
      tick(3);
      chk_reg("wrap_mem_kept", 2'd2, 8'd9);

      // Reset in the middle of execution
      reset = 1'b1;
      tick(2);
      reset = 1'b0;
      check("mrst_pc", {28'd0, pc}, 32'd0);
      check("mrst_busy_halt", {30'd0, busy, halted}, 32'd0);
      check("mrst_flags", {30'd0, flag_z, flag_c}, 32'd0);
      check("mrst_out", {23'd0, out_valid, out_data}, 32'd0);
      for (int i = 0; i < 4; i++) chk_reg("mrst_reg", 2'(i), 8'd0);
      tick(4);
      check("mrst_stays_idle", {28'd0, pc}, 32'd0);

      check("sb_empty", exp_q.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
